// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: N-master Wishbone classic arbiter in front of sdram_wb_controller.
// Optional stalled-strobe timeout/abort: define SDRAM_ARB_TIMEOUT_EN.
module sdram_wb_arbiter #(
   parameter int N_MASTERS   = 3,
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 16,
   parameter bit HIPRI_M0    = 1'b1,
   parameter int TIMEOUT_CYC = 64,
   localparam int SEL_W      = DATA_W / 8
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_n_i,
   input  logic [N_MASTERS-1:0]          m_cyc_i,
   input  logic [N_MASTERS-1:0]          m_stb_i,
   input  logic [N_MASTERS-1:0]          m_we_i,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_adr_i,
   input  logic [N_MASTERS*DATA_W-1:0]   m_dat_i,
   input  logic [N_MASTERS*SEL_W-1:0]    m_sel_i,
   output logic [N_MASTERS-1:0]          m_ack_o,
   output logic [N_MASTERS-1:0]          m_err_o,
   output logic [DATA_W-1:0]             m_dat_o,
   output logic                          s_cyc_o,
   output logic                          s_stb_o,
   output logic                          s_we_o,
   output logic [ADDR_W-1:0]             s_adr_o,
   output logic [DATA_W-1:0]             s_dat_o,
   output logic [SEL_W-1:0]              s_sel_o,
   input  logic                          s_ack_i,
   input  logic [DATA_W-1:0]             s_dat_i,
   output logic [N_MASTERS-1:0]          grant_o,
   output logic [1:0]                    arb_state_o
);

   localparam int PW = $clog2(N_MASTERS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_ABORT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]        rr_q, rr_d;
   logic [N_MASTERS-1:0] req;
   logic [PW-1:0]        gidx;
   logic [PW-1:0]        win;
   logic                 win_rr;
   logic                 busy;
   logic                 err_hit;

   assign req  = m_cyc_i & m_stb_i;
   assign busy = (state_q == S_BUSY);

   // Descending scan so the nearest requester after the pointer wins.
   always_comb begin
      win    = '0;
      win_rr = 1'b0;
      if (!(HIPRI_M0 && req[0])) begin
         win_rr = |req;
         for (int i = N_MASTERS; i >= 1; i--) begin
            if (req[(int'(rr_q) + i) % N_MASTERS])
               win = PW'((int'(rr_q) + i) % N_MASTERS);
         end
      end
   end

   always_comb begin
      gidx = '0;
      for (int k = 0; k < N_MASTERS; k++)
         if (grant_q[k]) gidx = PW'(k);
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC);
   logic [CW-1:0] cnt_q, cnt_d;

   assign err_hit = busy && m_cyc_i[gidx] && s_stb_o && !s_ack_i
                    && (cnt_q == CW'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!busy || s_ack_i || err_hit || !m_cyc_i[gidx])
         cnt_d = '0;
      else if (s_stb_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) cnt_q <= '0;
      else             cnt_q <= cnt_d;
   end
`else
   assign err_hit = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         rr_q    <= PW'(N_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_BUSY;
               grant_d = N_MASTERS'(1) << win;
               if (win_rr) rr_d = win;
            end
         end
         S_BUSY: begin
            if (!m_cyc_i[gidx]) begin
               state_d = S_IDLE;
               grant_d = '0;
            end else if (err_hit) begin
               state_d = S_ABORT;
               grant_d = '0;
            end
         end
         S_ABORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_comb begin
      s_cyc_o = busy & m_cyc_i[gidx];
      s_stb_o = busy & m_stb_i[gidx];
      s_we_o  = busy & m_we_i[gidx];
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      m_dat_o = '0;
      if (busy) begin
         s_adr_o = m_adr_i[int'(gidx)*ADDR_W +: ADDR_W];
         s_dat_o = m_dat_i[int'(gidx)*DATA_W +: DATA_W];
         s_sel_o = m_sel_i[int'(gidx)*SEL_W +: SEL_W];
         m_dat_o = s_dat_i;
      end
   end

   assign m_ack_o     = (busy && s_ack_i) ? grant_q : '0;
   assign m_err_o     = err_hit ? grant_q : '0;
   assign grant_o     = grant_q;
   assign arb_state_o = state_q;

endmodule
